window_scan_ctrl: RTL and testbench
===================================

Name: window_scan_ctrl

Overview:
Parametrised scan-address generator for the Sobel/convolution datapath. It walks a kernel window centre over the interior of an image, skipping a border of BORDER pixels on every side, in either raster or serpentine order. For each centre position it emits matching read and write addresses, the coordinates and the next move. Positions are handed over through a valid/ready handshake so the window buffer can apply backpressure. Replaces the fixed 3x3, serpentine-only move controller.

Parameters:
ADDR_W, 16, width of read/write addresses; all address arithmetic is modulo 2^ADDR_W.
DIM_W, 12, width of image dimensions and coordinates.
BORDER, 1, kernel radius in pixels; 3x3 kernel = 1, 5x5 = 2; legal range 0..7.

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
img_length  in  DIM_W  pixels per row (x extent)
img_width  in  DIM_W  rows (y extent)
mode  in  1  0 = raster, 1 = serpentine; sampled on accepted start
init_addr_r  in  ADDR_W  read address of pixel (BORDER, BORDER)
init_addr_w  in  ADDR_W  write address of pixel (BORDER, BORDER)
start  in  1  one-cycle request to begin a scan
abort  in  1  cancel scan, return to IDLE
pos_ready  in  1  consumer accepts the current position
pos_valid  out  1  current position valid
addr_r  out  ADDR_W  read address of current centre
addr_w  out  ADDR_W  write address of current centre
x  out  DIM_W  column of current centre
y  out  DIM_W  row of current centre
direction  out  2  move taken on acceptance: 01 right, 10 left, 11 down, 00 row-return (raster) or none (last)
pos_last  out  1  current position is the final one
busy  out  1  state == RUN
done  out  1  scan complete; held until the next start or reset
cfg_err  out  1  one-cycle pulse: start rejected

Behaviour:
- Reset: state IDLE; every output is 0.
- Region: x in [B, L-1-B], y in [B, W-1-B], where B = BORDER, L = img_length, W = img_width. Region width RW = L-2B, region height RH = W-2B. Each position is presented exactly once; total RW*RH positions.
- FSM states: IDLE, RUN, DONE.
- Start in IDLE or DONE:
  - If L < 2B+1 or W < 2B+1: pulse cfg_err and stay in (or return to) IDLE with done=0.
  - Otherwise latch L, W, mode and the init addresses; clear done; set x=y=B and addr_r/addr_w = init values.
  - Next cycle: state RUN, pos_valid=1.
- start while in RUN is ignored.
- Advance only on a cycle with pos_valid & pos_ready; outputs then update the next cycle. With pos_ready low, every output holds.
- Move deltas (applied identically to addr_r and addr_w):
  - right: +1, x+1
  - left: -1, x-1
  - down: +L, y+1
  - row-return: +(2B+1), x=B, y+1
- Raster order: direction=01 until x = L-1-B, then 00.
- Serpentine order:
  - Rows with even (y-B) move right; rows with odd (y-B) move left.
  - At the row end (x = L-1-B going right, or x = B going left) direction=11 and x is kept.
  - RW = 1 gives down only.
- Last position (x, y both at their final values): pos_last=1, direction=00.
  - Acceptance in raster leaves x = L-1-B, y = W-1-B.
  - Acceptance in serpentine leaves x at the end of the final row, which is L-1-B if RH is odd and B if RH is even; y = W-1-B.
  - The following cycle: state DONE, pos_valid=0, done=1, busy=0; addr_r, addr_w, x and y hold their last values.
- direction and pos_last are combinational from the registered position and latched config. All other outputs are registered.
- abort in RUN or DONE: next cycle IDLE, pos_valid=0, done=0. abort beats start and beats an acceptance in the same cycle.
- reset beats everything, including mid-scan; the state clears on the next edge.
- Inputs other than start, abort and pos_ready are ignored outside an accepted start.

Decomposition:
- Package scan_pkg holds:
  - the direction typedef (DIR_NONE_RET=2'b00, DIR_RIGHT, DIR_LEFT, DIR_DOWN);
  - the state enum;
  - the mode enum (SCAN_RASTER, SCAN_SERP).
- One sub-module, scan_addr_step: combinational next-position/next-direction logic (x, y, addrs, latched config, mode -> next values and pos_last), reused by a future multi-channel variant. The FSM and registers live in the top.

Test Plan:
- L=5, W=5, B=1, serpentine, init_r=0x10, pos_ready=1 -> addr_r sequence 10,11,12,17,16,15,1A,1B,1C; directions 01,01,11,10,10,11,01,01,00; pos_last only on 0x1C; done=1 the cycle after.
- Same config in raster -> 10,11,12,15,16,17,1A,1B,1C; directions 01,01,00,01,01,00,01,01,00.
- Backpressure: toggle pos_ready 1,0,0,1 -> outputs frozen while ready=0; no position skipped or repeated; 9 acceptances total.
- L=2, W=5, B=1 start -> cfg_err pulse for 1 cycle; pos_valid stays 0; state IDLE. L=W=3 -> single position with pos_last=1 and direction=00.
- ADDR_W=8, init_r=0xFE, L=7, W=3, B=1, raster -> addr_r FE,FF,00,01,02; wrap-around has no side effects.
- abort at the 4th position, and separately reset at the 4th position -> next cycle pos_valid=0, done=0, busy=0; a fresh start restarts at x=y=B with the init addresses.

Source files
------------

// File: rtl/window_scan_ctrl_pkg.sv
// Shared types for the window-centre scan controller: move codes, FSM states
// and scan order.
package scan_pkg;

    typedef enum logic [1:0] {
        DIR_NONE_RET = 2'b00,   // row-return in raster, or no move on the last position
        DIR_RIGHT    = 2'b01,
        DIR_LEFT     = 2'b10,
        DIR_DOWN     = 2'b11
    } dir_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    typedef enum logic {
        SCAN_RASTER = 1'b0,
        SCAN_SERP   = 1'b1
    } mode_e;

endpackage

// File: rtl/window_scan_ctrl_scan_addr_step.sv
// Combinational step logic: from the current centre position and the latched
// image configuration, work out the move to take, the position after that
// move and whether the current position is the final one.
module scan_addr_step
    import scan_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DIM_W  = 12,
    parameter int BORDER = 1
) (
    input  logic [DIM_W-1:0]  i_x,
    input  logic [DIM_W-1:0]  i_y,
    input  logic [ADDR_W-1:0] i_addr_r,
    input  logic [ADDR_W-1:0] i_addr_w,
    input  logic [DIM_W-1:0]  i_len,
    input  logic [DIM_W-1:0]  i_wid,
    input  mode_e             i_mode,
    output logic [DIM_W-1:0]  o_x_nxt,
    output logic [DIM_W-1:0]  o_y_nxt,
    output logic [ADDR_W-1:0] o_addr_r_nxt,
    output logic [ADDR_W-1:0] o_addr_w_nxt,
    output dir_e              o_dir,
    output logic              o_last
);

    localparam logic [DIM_W-1:0]  B_D      = DIM_W'(BORDER);
    localparam logic [DIM_W-1:0]  B1_D     = DIM_W'(BORDER + 1);
    localparam logic [DIM_W-1:0]  ONE_D    = DIM_W'(1);
    localparam logic [ADDR_W-1:0] ONE_A    = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] RET_STEP = ADDR_W'(2 * BORDER + 1);
    localparam logic              B_ODD    = ((BORDER % 2) == 1);

    logic [DIM_W-1:0]  w_x_end;
    logic [DIM_W-1:0]  w_y_end;
    logic [ADDR_W-1:0] w_down_step;
    logic              w_go_right;
    logic              w_at_row_end;
    logic              w_at_y_end;
    dir_e              w_dir;
    logic              w_last;

    assign w_x_end      = i_len - B1_D;
    assign w_y_end      = i_wid - B1_D;
    assign w_down_step  = ADDR_W'(i_len);
    assign w_at_y_end   = (i_y == w_y_end);
    // Parity of (y - BORDER) equals parity of y xor parity of BORDER.
    assign w_go_right   = (i_mode == SCAN_RASTER) || ((i_y[0] ^ B_ODD) == 1'b0);
    assign w_at_row_end = w_go_right ? (i_x == w_x_end) : (i_x == B_D);

    // Choose the move for the current position.
    always_comb begin
        w_dir  = DIR_NONE_RET;
        w_last = 1'b0;
        if (w_at_row_end && w_at_y_end) begin
            w_last = 1'b1;
            w_dir  = DIR_NONE_RET;
        end else if (!w_at_row_end) begin
            w_dir = w_go_right ? DIR_RIGHT : DIR_LEFT;
        end else if (i_mode == SCAN_SERP) begin
            w_dir = DIR_DOWN;
        end else begin
            w_dir = DIR_NONE_RET;
        end
    end

    // Apply the chosen move to coordinates and both addresses.
    always_comb begin
        o_x_nxt      = i_x;
        o_y_nxt      = i_y;
        o_addr_r_nxt = i_addr_r;
        o_addr_w_nxt = i_addr_w;
        case (w_dir)
            DIR_RIGHT: begin
                o_x_nxt      = i_x + ONE_D;
                o_addr_r_nxt = i_addr_r + ONE_A;
                o_addr_w_nxt = i_addr_w + ONE_A;
            end
            DIR_LEFT: begin
                o_x_nxt      = i_x - ONE_D;
                o_addr_r_nxt = i_addr_r - ONE_A;
                o_addr_w_nxt = i_addr_w - ONE_A;
            end
            DIR_DOWN: begin
                o_y_nxt      = i_y + ONE_D;
                o_addr_r_nxt = i_addr_r + w_down_step;
                o_addr_w_nxt = i_addr_w + w_down_step;
            end
            DIR_NONE_RET: begin
                if (w_last) begin
                    o_x_nxt = i_x;
                    o_y_nxt = i_y;
                end else begin
                    o_x_nxt      = B_D;
                    o_y_nxt      = i_y + ONE_D;
                    o_addr_r_nxt = i_addr_r + RET_STEP;
                    o_addr_w_nxt = i_addr_w + RET_STEP;
                end
            end
            default: begin
                o_x_nxt = i_x;
                o_y_nxt = i_y;
            end
        endcase
    end

    assign o_dir  = w_dir;
    assign o_last = w_last;

endmodule

// File: rtl/window_scan_ctrl.sv
// Window-centre scan controller: validates and latches the image
// configuration on start, then presents one centre position per handshake
// until the whole interior region has been visited.
module window_scan_ctrl
    import scan_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DIM_W  = 12,
    parameter int BORDER = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DIM_W-1:0]  img_length,
    input  logic [DIM_W-1:0]  img_width,
    input  logic              mode,
    input  logic [ADDR_W-1:0] init_addr_r,
    input  logic [ADDR_W-1:0] init_addr_w,
    input  logic              start,
    input  logic              abort,
    input  logic              pos_ready,
    output logic              pos_valid,
    output logic [ADDR_W-1:0] addr_r,
    output logic [ADDR_W-1:0] addr_w,
    output logic [DIM_W-1:0]  x,
    output logic [DIM_W-1:0]  y,
    output logic [1:0]        direction,
    output logic              pos_last,
    output logic              busy,
    output logic              done,
    output logic              cfg_err
);

    localparam logic [DIM_W-1:0] B_D     = DIM_W'(BORDER);
    localparam logic [DIM_W-1:0] MIN_DIM = DIM_W'(2 * BORDER + 1);

    state_e            r_state,     w_state_nxt;
    logic [DIM_W-1:0]  r_x,         w_x_nxt;
    logic [DIM_W-1:0]  r_y,         w_y_nxt;
    logic [ADDR_W-1:0] r_addr_r,    w_addr_r_nxt;
    logic [ADDR_W-1:0] r_addr_w,    w_addr_w_nxt;
    logic [DIM_W-1:0]  r_len,       w_len_nxt;
    logic [DIM_W-1:0]  r_wid,       w_wid_nxt;
    mode_e             r_mode,      w_mode_nxt;
    logic              r_pos_valid, w_pos_valid_nxt;
    logic              r_busy,      w_busy_nxt;
    logic              r_done,      w_done_nxt;
    logic              r_cfg_err,   w_cfg_err_nxt;

    logic [DIM_W-1:0]  w_step_x;
    logic [DIM_W-1:0]  w_step_y;
    logic [ADDR_W-1:0] w_step_addr_r;
    logic [ADDR_W-1:0] w_step_addr_w;
    dir_e              w_step_dir;
    logic              w_step_last;
    logic              w_cfg_bad;
    logic              w_accept;

    scan_addr_step #(
        .ADDR_W (ADDR_W),
        .DIM_W  (DIM_W),
        .BORDER (BORDER)
    ) u_step (
        .i_x          (r_x),
        .i_y          (r_y),
        .i_addr_r     (r_addr_r),
        .i_addr_w     (r_addr_w),
        .i_len        (r_len),
        .i_wid        (r_wid),
        .i_mode       (r_mode),
        .o_x_nxt      (w_step_x),
        .o_y_nxt      (w_step_y),
        .o_addr_r_nxt (w_step_addr_r),
        .o_addr_w_nxt (w_step_addr_w),
        .o_dir        (w_step_dir),
        .o_last       (w_step_last)
    );

    assign w_cfg_bad = (img_length < MIN_DIM) || (img_width < MIN_DIM);
    assign w_accept  = r_pos_valid && pos_ready;

    // Next state and next register values; abort overrides start and acceptance.
    always_comb begin
        w_state_nxt     = r_state;
        w_x_nxt         = r_x;
        w_y_nxt         = r_y;
        w_addr_r_nxt    = r_addr_r;
        w_addr_w_nxt    = r_addr_w;
        w_len_nxt       = r_len;
        w_wid_nxt       = r_wid;
        w_mode_nxt      = r_mode;
        w_pos_valid_nxt = r_pos_valid;
        w_busy_nxt      = r_busy;
        w_done_nxt      = r_done;
        w_cfg_err_nxt   = 1'b0;
        if (abort) begin
            w_state_nxt     = ST_IDLE;
            w_pos_valid_nxt = 1'b0;
            w_busy_nxt      = 1'b0;
            w_done_nxt      = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start && w_cfg_bad) begin
                        w_state_nxt     = ST_IDLE;
                        w_pos_valid_nxt = 1'b0;
                        w_busy_nxt      = 1'b0;
                        w_done_nxt      = 1'b0;
                        w_cfg_err_nxt   = 1'b1;
                    end else if (start) begin
                        w_state_nxt     = ST_RUN;
                        w_len_nxt       = img_length;
                        w_wid_nxt       = img_width;
                        w_mode_nxt      = mode_e'(mode);
                        w_x_nxt         = B_D;
                        w_y_nxt         = B_D;
                        w_addr_r_nxt    = init_addr_r;
                        w_addr_w_nxt    = init_addr_w;
                        w_pos_valid_nxt = 1'b1;
                        w_busy_nxt      = 1'b1;
                        w_done_nxt      = 1'b0;
                    end else begin
                        w_state_nxt = r_state;
                    end
                end
                ST_RUN: begin
                    if (w_accept && w_step_last) begin
                        w_state_nxt     = ST_DONE;
                        w_pos_valid_nxt = 1'b0;
                        w_busy_nxt      = 1'b0;
                        w_done_nxt      = 1'b1;
                    end else if (w_accept) begin
                        w_x_nxt      = w_step_x;
                        w_y_nxt      = w_step_y;
                        w_addr_r_nxt = w_step_addr_r;
                        w_addr_w_nxt = w_step_addr_w;
                    end else begin
                        w_state_nxt = ST_RUN;
                    end
                end
                default: begin
                    w_state_nxt     = ST_IDLE;
                    w_pos_valid_nxt = 1'b0;
                    w_busy_nxt      = 1'b0;
                    w_done_nxt      = 1'b0;
                end
            endcase
        end
    end

    // State, position, configuration and status registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_x         <= '0;
            r_y         <= '0;
            r_addr_r    <= '0;
            r_addr_w    <= '0;
            r_len       <= '0;
            r_wid       <= '0;
            r_mode      <= SCAN_RASTER;
            r_pos_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_cfg_err   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_x         <= w_x_nxt;
            r_y         <= w_y_nxt;
            r_addr_r    <= w_addr_r_nxt;
            r_addr_w    <= w_addr_w_nxt;
            r_len       <= w_len_nxt;
            r_wid       <= w_wid_nxt;
            r_mode      <= w_mode_nxt;
            r_pos_valid <= w_pos_valid_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            r_cfg_err   <= w_cfg_err_nxt;
        end
    end

    // Move and last flag only mean something while a position is presented.
    assign direction = r_pos_valid ? w_step_dir : DIR_NONE_RET;
    assign pos_last  = r_pos_valid && w_step_last;
    assign pos_valid = r_pos_valid;
    assign addr_r    = r_addr_r;
    assign addr_w    = r_addr_w;
    assign x         = r_x;
    assign y         = r_y;
    assign busy      = r_busy;
    assign done      = r_done;
    assign cfg_err   = r_cfg_err;

endmodule

// File: tb/tb_window_scan_ctrl.sv
// Self-checking bench for window_scan_ctrl: directed vector table, hand-written
// corner sequences and randomized scans against a position-list model.
module tb_window_scan_ctrl;

    localparam int TB_B = 1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [11:0] img_length = 12'd0;
    logic [11:0] img_width = 12'd0;
    logic        mode = 1'b0;
    logic [15:0] init_addr_r = 16'd0;
    logic [15:0] init_addr_w = 16'd0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        pos_ready = 1'b0;
    logic        pos_valid, pos_last, busy, done, cfg_err;
    logic [15:0] addr_r, addr_w;
    logic [11:0] x, y;
    logic [1:0]  direction;

    logic [7:0]  init8_r = 8'd0;
    logic [7:0]  init8_w = 8'd0;
    logic        start8 = 1'b0;
    logic        pos_ready8 = 1'b0;
    logic        pos_valid8, pos_last8, busy8, done8, cfg_err8;
    logic [7:0]  addr_r8, addr_w8;
    logic [11:0] x8, y8;
    logic [1:0]  direction8;

    always #5 clk = ~clk;

    window_scan_ctrl #(.ADDR_W(16), .DIM_W(12), .BORDER(1)) dut (
        .clk(clk), .reset(reset), .img_length(img_length), .img_width(img_width),
        .mode(mode), .init_addr_r(init_addr_r), .init_addr_w(init_addr_w),
        .start(start), .abort(abort), .pos_ready(pos_ready),
        .pos_valid(pos_valid), .addr_r(addr_r), .addr_w(addr_w), .x(x), .y(y),
        .direction(direction), .pos_last(pos_last), .busy(busy), .done(done),
        .cfg_err(cfg_err)
    );

    window_scan_ctrl #(.ADDR_W(8), .DIM_W(12), .BORDER(1)) dut8 (
        .clk(clk), .reset(reset), .img_length(img_length), .img_width(img_width),
        .mode(mode), .init_addr_r(init8_r), .init_addr_w(init8_w),
        .start(start8), .abort(abort), .pos_ready(pos_ready8),
        .pos_valid(pos_valid8), .addr_r(addr_r8), .addr_w(addr_w8), .x(x8), .y(y8),
        .direction(direction8), .pos_last(pos_last8), .busy(busy8), .done(done8),
        .cfg_err(cfg_err8)
    );

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [15:0] ar;
        logic [15:0] aw;
        logic [11:0] x;
        logic [11:0] y;
        logic [1:0]  dir;
        logic        last;
    } pos_t;

    pos_t q[$];

    typedef struct packed {
        logic [11:0]       l;
        logic [11:0]       w;
        logic              m;
        logic [15:0]       ir;
        logic [3:0]        n;
        logic [8:0][15:0]  ar;
        logic [8:0][1:0]   dir;
    } tvec_t;

    tvec_t tv [3];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Position list in visiting order: address = init + (y-B)*L + (x-B).
    task automatic build_model(input int l, input int w, input logic m,
                               input logic [15:0] ir, input logic [15:0] iw);
        int   rw, rh, xx;
        pos_t p;
        q.delete();
        rw = l - 2 * TB_B;
        rh = w - 2 * TB_B;
        for (int r = 0; r < rh; r++) begin
            for (int k = 0; k < rw; k++) begin
                xx     = (m && (r % 2 == 1)) ? (TB_B + rw - 1 - k) : (TB_B + k);
                p.ar   = ir + 16'(r * l + xx - TB_B);
                p.aw   = iw + 16'(r * l + xx - TB_B);
                p.x    = 12'(xx);
                p.y    = 12'(TB_B + r);
                p.dir  = 2'b00;
                p.last = 1'b0;
                q.push_back(p);
            end
        end
        for (int i = 0; i < q.size(); i++) begin
            p = q[i];
            if (i == q.size() - 1) p.last = 1'b1;
            else if (q[i+1].y == p.y) p.dir = (q[i+1].x > p.x) ? 2'b01 : 2'b10;
            else p.dir = m ? 2'b11 : 2'b00;
            q[i] = p;
        end
    endtask

    task automatic do_start(input int l, input int w, input logic m,
                            input logic [15:0] ir, input logic [15:0] iw);
        @(negedge clk);
        img_length  = 12'(l);
        img_width   = 12'(w);
        mode        = m;
        init_addr_r = ir;
        init_addr_w = iw;
        pos_ready   = 1'b0;
        start       = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // pct < 0 selects the fixed ready pattern 1,0,0,1.
    task automatic run_scan(input int l, input int w, input logic m,
                            input logic [15:0] ir, input logic [15:0] iw,
                            input int pct, input bit jitter);
        int   guard, acc, expn;
        pos_t lastp;
        if (l < 2 * TB_B + 1 || w < 2 * TB_B + 1) begin
            do_start(l, w, m, ir, iw);
            check("cfg_err_pulse", {cfg_err, pos_valid, busy, done}, 4'b1000);
            @(negedge clk);
            check("cfg_err_clear", {cfg_err, pos_valid, busy, done}, 4'b0000);
        end else begin
            build_model(l, w, m, ir, iw);
            expn  = q.size();
            lastp = q[q.size() - 1];
            do_start(l, w, m, ir, iw);
            guard = 0;
            acc   = 0;
            while (q.size() > 0 && guard < 2000) begin
                if (jitter) begin
                    mode        = 1'($urandom);
                    img_length  = 12'($urandom_range(1, 20));
                    img_width   = 12'($urandom_range(1, 20));
                    init_addr_r = 16'($urandom);
                    start       = 1'($urandom);
                end
                check("valid_busy", {pos_valid, busy, done}, 3'b110);
                check("position", {addr_r, addr_w, x, y, direction, pos_last}, q[0]);
                if (pct < 0) pos_ready = ((guard % 4) == 0) || ((guard % 4) == 3);
                else pos_ready = ($urandom_range(0, 99) < pct);
                @(negedge clk);
                if (pos_ready) begin
                    void'(q.pop_front());
                    acc++;
                end
                guard++;
            end
            start     = 1'b0;
            pos_ready = 1'b0;
            check("scan_timeout", q.size(), 0);
            check("accept_count", acc, expn);
            check("end_flags", {pos_valid, busy, done, direction, pos_last}, 6'b001000);
            check("end_hold", {addr_r, addr_w, x, y}, {lastp.ar, lastp.aw, lastp.x, lastp.y});
        end
    endtask

    logic [7:0] e8;

    initial begin
        tv[0] = '{l: 12'd5, w: 12'd5, m: 1'b1, ir: 16'h0010, n: 4'd9,
                  ar: {16'h001C, 16'h001B, 16'h001A, 16'h0015, 16'h0016, 16'h0017, 16'h0012, 16'h0011, 16'h0010},
                  dir: {2'b00, 2'b01, 2'b01, 2'b11, 2'b10, 2'b10, 2'b11, 2'b01, 2'b01}};
        tv[1] = '{l: 12'd5, w: 12'd5, m: 1'b0, ir: 16'h0010, n: 4'd9,
                  ar: {16'h001C, 16'h001B, 16'h001A, 16'h0017, 16'h0016, 16'h0015, 16'h0012, 16'h0011, 16'h0010},
                  dir: {2'b00, 2'b01, 2'b01, 2'b00, 2'b01, 2'b01, 2'b00, 2'b01, 2'b01}};
        tv[2] = '{l: 12'd3, w: 12'd3, m: 1'b1, ir: 16'h0040, n: 4'd1,
                  ar: {16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0040},
                  dir: {2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00}};

        // Reset state of both instances.
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("reset_outputs", {pos_valid, addr_r, addr_w, x, y, direction, pos_last, busy, done, cfg_err}, 64'd0);
        check("reset_outputs8", {pos_valid8, addr_r8, addr_w8, x8, y8, direction8, pos_last8, busy8, done8, cfg_err8}, 64'd0);

        // Directed vector table, ready held high.
        for (int t = 0; t < 3; t++) begin
            do_start(int'(tv[t].l), int'(tv[t].w), tv[t].m, tv[t].ir, tv[t].ir + 16'h0200);
            for (int i = 0; i < int'(tv[t].n); i++) begin
                check("tv_addr_r", addr_r, tv[t].ar[i]);
                check("tv_addr_w", addr_w, tv[t].ar[i] + 16'h0200);
                check("tv_dir", direction, tv[t].dir[i]);
                check("tv_last", pos_last, (i == int'(tv[t].n) - 1));
                pos_ready = 1'b1;
                @(negedge clk);
            end
            pos_ready = 1'b0;
            check("tv_done", {pos_valid, busy, done}, 3'b001);
        end

        // Abort from DONE clears done.
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_done", {pos_valid, busy, done}, 3'b000);

        // Too-narrow image is rejected.
        run_scan(2, 5, 1'b0, 16'h0010, 16'h0020, 100, 1'b0);

        // Backpressure with ready pattern 1,0,0,1.
        run_scan(5, 5, 1'b1, 16'h0010, 16'h0300, -1, 1'b0);

        // Abort at the 4th position, competing with an acceptance.
        do_start(5, 5, 1'b1, 16'h0010, 16'h0300);
        pos_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("abort_pos4", addr_r, 16'h0017);
        abort = 1'b1;
        @(negedge clk);
        abort     = 1'b0;
        pos_ready = 1'b0;
        check("abort_flags", {pos_valid, busy, done}, 3'b000);
        run_scan(5, 5, 1'b1, 16'h0010, 16'h0300, 100, 1'b0);

        // Reset at the 4th position.
        do_start(5, 5, 1'b0, 16'h0010, 16'h0300);
        pos_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_pos4", addr_r, 16'h0015);
        reset = 1'b1;
        @(negedge clk);
        reset     = 1'b0;
        pos_ready = 1'b0;
        check("reset_mid", {pos_valid, addr_r, addr_w, x, y, direction, pos_last, busy, done, cfg_err}, 64'd0);
        run_scan(5, 5, 1'b0, 16'h0010, 16'h0300, 100, 1'b0);

        // 8-bit address wrap-around.
        @(negedge clk);
        img_length = 12'd7;
        img_width  = 12'd3;
        mode       = 1'b0;
        init8_r    = 8'hFE;
        init8_w    = 8'h7F;
        pos_ready8 = 1'b1;
        start8     = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            e8 = 8'hFE + 8'(i);
            check("wrap_addr_r", addr_r8, e8);
            e8 = 8'h7F + 8'(i);
            check("wrap_addr_w", addr_w8, e8);
            check("wrap_xy", {x8, y8, direction8, pos_last8}, {12'(1 + i), 12'd1, (i == 4) ? 2'b00 : 2'b01, (i == 4)});
            @(negedge clk);
        end
        pos_ready8 = 1'b0;
        check("wrap_end", {pos_valid8, busy8, done8, addr_r8}, {3'b001, 8'h02});

        // Randomized scans against the model, with config inputs jittered mid-scan.
        for (int s = 0; s < 25; s++) begin
            run_scan($urandom_range(1, 9), $urandom_range(1, 8), 1'($urandom),
                     16'($urandom), 16'($urandom), $urandom_range(30, 100), 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
